// File: rtl/relogio_pkg.sv
// -----------------------------------------------------------------------------
// relogio_pkg
// Shared types and constants for the digital-clock timekeeping controller.
//   state_e  : controller FSM states (RUN, SET_HOUR, SET_MIN); 2'd3 is unused
//   *_W      : bit widths of the hours / minutes / seconds fields
//   *_MOD    : modulus of each field (24 / 60 / 60)
// -----------------------------------------------------------------------------
package relogio_pkg;

  localparam int HOUR_W   = 5;
  localparam int MIN_W    = 6;
  localparam int SEC_W    = 6;
  localparam int STATE_W  = 2;

  localparam int HOUR_MOD = 24;
  localparam int MIN_MOD  = 60;
  localparam int SEC_MOD  = 60;

  // Encoding is visible on ctrl_state, so the values are fixed explicitly.
  typedef enum logic [STATE_W-1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2
  } state_e;

endpackage

// File: rtl/relogio_ctrl_wrap_counter.sv
// -----------------------------------------------------------------------------
// wrap_counter
// Modulo up-counter used for the seconds, minutes and hours fields.
// Parameters:
//   W       : counter width
//   the modulus parameter counts 0 .. modulus-1, then wraps to 0
//   RST_VAL : value loaded by the synchronous active-low reset
// Ports:
//   i_clk    in  1  clock
//   i_rst_n  in  1  synchronous, active-low reset (highest priority)
//   i_en     in  1  advance by one this cycle
//   i_clr    in  1  synchronous clear to 0 (wins over i_en)
//   o_count  out W  registered count
//   o_carry  out 1  combinational: high when an enabled step wraps to 0
// -----------------------------------------------------------------------------
module wrap_counter #(
  parameter int             W       = 6,
  parameter int             MOD     = 60,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_en,
  input  logic         i_clr,
  output logic [W-1:0] o_count,
  output logic         o_carry
);

  localparam logic [W-1:0] LAST = W'(MOD - 1);

  logic [W-1:0] r_count;
  logic         w_at_last;

  assign w_at_last = (r_count == LAST);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_count <= RST_VAL;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= w_at_last ? '0 : r_count + 1'b1;
    end
  end

  // Carry is combinational so the next field up advances on the same edge;
  // a whole 23:59:59 -> 00:00:00 cascade therefore lands in one cycle.
  assign o_carry = i_en & ~i_clr & w_at_last;
  assign o_count = r_count;

endmodule

// File: rtl/relogio_ctrl.sv
// -----------------------------------------------------------------------------
// relogio_ctrl
// Timekeeping controller for the digital clock. Counts hours/minutes/seconds
// from the 1 Hz tick in RUN, and lets the user set hours and minutes with two
// debounced buttons (mode steps RUN -> SET_HOUR -> SET_MIN -> RUN, inc bumps
// the field being set).
//
// Optional feature macro: CTRL_BLINK_EN
//   defined   : a blink phase toggles on each tick in set states and drives
//               ctrl_blank for the field being edited
//   undefined : no phase register, ctrl_blank is constant 3'b000
//
// Parameters:
//   INIT_HOUR  hour loaded on reset (0..23)
//   INIT_MIN   minute loaded on reset (0..59)
// Ports:
//   ctrl_clock      in  1  system clock
//   ctrl_reset_n    in  1  synchronous, active-low reset
//   ctrl_tick       in  1  1 Hz enable, one clock wide
//   ctrl_mode       in  1  mode button level (debounced, active-high)
//   ctrl_inc        in  1  increment button level (debounced, active-high)
//   ctrl_hours      out 5  hours 0..23
//   ctrl_minutes    out 6  minutes 0..59
//   ctrl_seconds    out 6  seconds 0..59
//   ctrl_state      out 2  FSM state (0 RUN, 1 SET_HOUR, 2 SET_MIN)
//   ctrl_blank      out 3  blank mask {hours, minutes, seconds}, 1 = blank
//   ctrl_carry_day  out 1  one-cycle pulse while outputs first show 00:00:00
//
// Event semantics: ctrl_tick is a qualifier sampled on every rising edge and
// acts only in the cycle it is high; there is no back-pressure. Buttons are
// levels; a press is a 0->1 transition seen against a one-cycle history, so a
// held button counts once. Every output is a register or a decode of
// registers and shows the effect of an event one cycle after it is sampled.
// -----------------------------------------------------------------------------
module relogio_ctrl
  import relogio_pkg::*;
#(
  parameter int INIT_HOUR = 0,
  parameter int INIT_MIN  = 0
) (
  input  logic                ctrl_clock,
  input  logic                ctrl_reset_n,
  input  logic                ctrl_tick,
  input  logic                ctrl_mode,
  input  logic                ctrl_inc,
  output logic [HOUR_W-1:0]   ctrl_hours,
  output logic [MIN_W-1:0]    ctrl_minutes,
  output logic [SEC_W-1:0]    ctrl_seconds,
  output logic [STATE_W-1:0]  ctrl_state,
  output logic [2:0]          ctrl_blank,
  output logic                ctrl_carry_day
);

  // ---------------------------------------------------------------------------
  // Button edge detection
  // ---------------------------------------------------------------------------
  logic r_mode_hist;
  logic r_inc_hist;
  logic w_mode_press;
  logic w_inc_press;
  logic w_inc_eff;

  // History resets to 1 so a button held through reset is not seen as a press.
  always_ff @(posedge ctrl_clock) begin
    if (!ctrl_reset_n) begin
      r_mode_hist <= 1'b1;
      r_inc_hist  <= 1'b1;
    end else begin
      r_mode_hist <= ctrl_mode;
      r_inc_hist  <= ctrl_inc;
    end
  end

  assign w_mode_press = ctrl_mode & ~r_mode_hist;
  assign w_inc_press  = ctrl_inc  & ~r_inc_hist;
  // A mode press in the same cycle discards the increment.
  assign w_inc_eff    = w_inc_press & ~w_mode_press;

  // ---------------------------------------------------------------------------
  // FSM: state register / next-state / output decode
  // ---------------------------------------------------------------------------
  state_e r_state;
  state_e w_next_state;
  logic   w_is_run;
  logic   w_is_set_hour;
  logic   w_is_set_min;
  logic   w_phase;
  logic   [2:0] w_blank;

  always_ff @(posedge ctrl_clock) begin
    if (!ctrl_reset_n) begin
      r_state <= RUN;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      RUN:      if (w_mode_press) w_next_state = SET_HOUR;
      SET_HOUR: if (w_mode_press) w_next_state = SET_MIN;
      SET_MIN:  if (w_mode_press) w_next_state = RUN;
      default:  w_next_state = RUN;  // unused encoding recovers to RUN
    endcase
  end

  always_comb begin
    w_is_run      = (r_state == RUN);
    w_is_set_hour = (r_state == SET_HOUR);
    w_is_set_min  = (r_state == SET_MIN);
    w_blank       = {w_is_set_hour & w_phase, w_is_set_min & w_phase, 1'b0};
  end

  // ---------------------------------------------------------------------------
  // Blink phase
  // ---------------------------------------------------------------------------
`ifdef CTRL_BLINK_EN
  logic r_phase;

  // Restarts at 0 whenever a set state is entered or left and on every inc
  // press, so the field is always visible right after it is touched.
  always_ff @(posedge ctrl_clock) begin
    if (!ctrl_reset_n) begin
      r_phase <= 1'b0;
    end else if ((w_next_state != r_state) || w_is_run) begin
      r_phase <= 1'b0;
    end else if (w_inc_press) begin
      r_phase <= 1'b0;
    end else if (ctrl_tick) begin
      r_phase <= ~r_phase;
    end
  end

  assign w_phase = r_phase;
`else
  assign w_phase = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Time field counters
  // ---------------------------------------------------------------------------
  logic w_sec_en;
  logic w_sec_clr;
  logic w_sec_co;
  logic w_min_en;
  logic w_min_co;
  logic w_hour_en;
  logic w_hour_co;
  logic r_carry_day;

  // Ticks only advance time in RUN; set states freeze seconds.
  assign w_sec_en  = w_is_run & ctrl_tick;
  // Leaving SET_MIN restarts the minute cleanly at :00.
  assign w_sec_clr = w_is_set_min & w_mode_press;
  assign w_min_en  = (w_is_run & w_sec_co) | (w_is_set_min & w_inc_eff);
  assign w_hour_en = (w_is_run & w_min_co) | (w_is_set_hour & w_inc_eff);

  wrap_counter #(
    .W       (SEC_W),
    .MOD     (SEC_MOD),
    .RST_VAL ('0)
  ) u_sec (
    .i_clk   (ctrl_clock),
    .i_rst_n (ctrl_reset_n),
    .i_en    (w_sec_en),
    .i_clr   (w_sec_clr),
    .o_count (ctrl_seconds),
    .o_carry (w_sec_co)
  );

  wrap_counter #(
    .W       (MIN_W),
    .MOD     (MIN_MOD),
    .RST_VAL (MIN_W'(INIT_MIN))
  ) u_min (
    .i_clk   (ctrl_clock),
    .i_rst_n (ctrl_reset_n),
    .i_en    (w_min_en),
    .i_clr   (1'b0),
    .o_count (ctrl_minutes),
    .o_carry (w_min_co)
  );

  wrap_counter #(
    .W       (HOUR_W),
    .MOD     (HOUR_MOD),
    .RST_VAL (HOUR_W'(INIT_HOUR))
  ) u_hour (
    .i_clk   (ctrl_clock),
    .i_rst_n (ctrl_reset_n),
    .i_en    (w_hour_en),
    .i_clr   (1'b0),
    .o_count (ctrl_hours),
    .o_carry (w_hour_co)
  );

  // Registered alongside the counters, so the pulse coincides with 00:00:00.
  // Hour wraps from the inc button in SET_HOUR are not a day rollover.
  always_ff @(posedge ctrl_clock) begin
    if (!ctrl_reset_n) begin
      r_carry_day <= 1'b0;
    end else begin
      r_carry_day <= w_is_run & w_hour_co;
    end
  end

  assign ctrl_state     = r_state;
  assign ctrl_blank     = w_blank;
  assign ctrl_carry_day = r_carry_day;

endmodule
